// File: rtl/demapper.sv
// Hard-decision 802.11a demapper: slices one I/Q point to Nbpsc Gray bits
// and streams them out serially, b0 first, one bit per clock.
//
// state | meaning
// IDLE  | no bits pending; oValid low, ready for a point
// SHIFT | bitsLeft >= 1 bits being presented; ready again on the last bit
module demapper #(
  parameter int W     = 8,
  parameter int THR16 = 64,
  parameter int NSC   = 48
) (
  input  logic         iClk,
  input  logic         iRst,
  input  logic         iRateEN,
  input  logic [3:0]   iRate,
  input  logic         iValid,
  input  logic [W-1:0] iI,
  input  logic [W-1:0] iQ,
  output logic         oReady,
  output logic         oData,
  output logic         oValid,
  output logic         oSymEnd
);

  localparam int SCW = (NSC > 1) ? $clog2(NSC) : 1;
  localparam logic [SCW-1:0] SC_LAST = SCW'(NSC - 1);
  localparam logic [W:0]     THR     = (W+1)'(THR16);
  localparam logic [W:0]     ONE     = (W+1)'(1);

  typedef enum logic {IDLE, SHIFT} stateT;

  stateT          state;
  logic [3:0]     rate;
  logic [3:0]     shiftReg;
  logic [3:0]     slice;
  logic [2:0]     bitsLeft;
  logic [2:0]     nbpsc;
  logic [SCW-1:0] scCnt;
  logic [SCW-1:0] scNext;
  logic [W:0]     iExt, qExt, absI, absQ;
  logic           accept;
  logic           lastBit;

  // Magnitudes carry one extra bit so the most negative sample stays positive.
  always_comb begin
    iExt = {iI[W-1], iI};
    qExt = {iQ[W-1], iQ};
    absI = iI[W-1] ? (~iExt + ONE) : iExt;
    absQ = iQ[W-1] ? (~qExt + ONE) : qExt;
  end

  always_comb begin
    case (rate)
      4'b1101, 4'b1111: nbpsc = 3'd1;
      4'b0101, 4'b0111: nbpsc = 3'd2;
      4'b1001, 4'b1011: nbpsc = 3'd4;
      default:          nbpsc = 3'd1;
    endcase
  end

  always_comb begin
    case (nbpsc)
      3'd4:    slice = {absQ < THR, ~iQ[W-1], absI < THR, ~iI[W-1]};
      3'd2:    slice = {2'b00, ~iQ[W-1], ~iI[W-1]};
      default: slice = {3'b000, ~iI[W-1]};
    endcase
  end

  assign lastBit = (state == SHIFT) && (bitsLeft == 3'd1);
  assign oReady  = ~iRateEN && ((state == IDLE) || lastBit);
  assign accept  = iValid && oReady;

  always_comb begin
    scNext = scCnt;
    if (lastBit) begin
      scNext = (scCnt == SC_LAST) ? '0 : scCnt + 1'b1;
    end
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state    <= IDLE;
      rate     <= 4'b1101;
      shiftReg <= '0;
      bitsLeft <= '0;
      scCnt    <= '0;
      oData    <= 1'b0;
      oValid   <= 1'b0;
      oSymEnd  <= 1'b0;
    end else if (iRateEN) begin
      // The bit on oData this cycle has already gone out; everything after it is dropped.
      state    <= IDLE;
      rate     <= iRate;
      shiftReg <= '0;
      bitsLeft <= '0;
      scCnt    <= '0;
      oData    <= 1'b0;
      oValid   <= 1'b0;
      oSymEnd  <= 1'b0;
    end else begin
      scCnt <= scNext;
      if (accept) begin
        state    <= SHIFT;
        oData    <= slice[0];
        oValid   <= 1'b1;
        shiftReg <= {1'b0, slice[3:1]};
        bitsLeft <= nbpsc;
        oSymEnd  <= (nbpsc == 3'd1) && (scNext == SC_LAST);
      end else if ((state == SHIFT) && (bitsLeft > 3'd1)) begin
        oData    <= shiftReg[0];
        oValid   <= 1'b1;
        shiftReg <= shiftReg >> 1;
        bitsLeft <= bitsLeft - 3'd1;
        oSymEnd  <= (bitsLeft == 3'd2) && (scNext == SC_LAST);
      end else begin
        state    <= IDLE;
        bitsLeft <= '0;
        oData    <= 1'b0;
        oValid   <= 1'b0;
        oSymEnd  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_demapper.sv
// Bench for demapper: constellation vector table, hand-written handshake,
// flush and reset sequences, then randomized traffic against a bit-queue model.
module tb_demapper;
  localparam int W     = 8;
  localparam int THR16 = 64;
  localparam int NSC   = 48;

  logic         iClk = 1'b0;
  logic         iRst;
  logic         iRateEN;
  logic [3:0]   iRate;
  logic         iValid;
  logic [W-1:0] iI;
  logic [W-1:0] iQ;
  logic         oReady, oData, oValid, oSymEnd;

  always #5 iClk = ~iClk;

  demapper #(.W(W), .THR16(THR16), .NSC(NSC)) dut (
    .iClk(iClk), .iRst(iRst), .iRateEN(iRateEN), .iRate(iRate),
    .iValid(iValid), .iI(iI), .iQ(iQ),
    .oReady(oReady), .oData(oData), .oValid(oValid), .oSymEnd(oSymEnd)
  );

  int checks = 0;
  int errors = 0;

  // Model: queue of bits still to appear on oData, each tagged with its oSymEnd value.
  typedef struct {bit d; bit se;} bitT;
  bitT        mq[$];
  int         pointIdx = 0;
  logic [3:0] mRate = 4'b1101;
  int         acceptCnt = 0;
  bit         lastAccept;
  logic       obsData, obsValid, obsReady, obsSymEnd;

  typedef struct {logic [3:0] rate; int i; int q; int n; logic [3:0] exp;} vecT;
  vecT tbl[14];

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkInt(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int nbpscOf(input logic [3:0] r);
    case (r)
      4'b0101, 4'b0111: return 2;
      4'b1001, 4'b1011: return 4;
      default:          return 1;
    endcase
  endfunction

  function automatic logic [3:0] sliceRef(input logic [3:0] r, input int si, input int sq);
    int ai = (si < 0) ? -si : si;
    int aq = (sq < 0) ? -sq : sq;
    case (nbpscOf(r))
      4:       return {aq < THR16, sq >= 0, ai < THR16, si >= 0};
      2:       return {2'b00, sq >= 0, si >= 0};
      default: return {3'b000, si >= 0};
    endcase
  endfunction

  // One clock: drive at negedge, check at negedge+1, advance model, wait for next negedge.
  task automatic step(input logic v, input int i, input int q, input logic ren, input logic [3:0] r);
    bit         mReady;
    logic [3:0] b;
    int         n;
    bitT        e;
    iValid = v; iI = W'(i); iQ = W'(q); iRateEN = ren; iRate = r;
    #1;
    obsData = oData; obsValid = oValid; obsReady = oReady; obsSymEnd = oSymEnd;
    check("oValid", oValid, mq.size() > 0);
    if (mq.size() > 0) begin
      check("oData", oData, mq[0].d);
      check("oSymEnd", oSymEnd, mq[0].se);
    end else begin
      check("oSymEnd_idle", oSymEnd, 1'b0);
    end
    mReady = !ren && (mq.size() <= 1);
    check("oReady", oReady, mReady);
    lastAccept = 0;
    if (ren) begin
      mq.delete();
      pointIdx = 0;
      mRate = r;
    end else begin
      if (mq.size() > 0) void'(mq.pop_front());
      if (v && mReady) begin
        b = sliceRef(mRate, i, q);
        n = nbpscOf(mRate);
        for (int k = 0; k < n; k++) begin
          e.d  = b[k];
          e.se = (k == n - 1) && (pointIdx % NSC == NSC - 1);
          mq.push_back(e);
        end
        pointIdx++;
        acceptCnt++;
        lastAccept = 1;
      end
    end
    @(posedge iClk);
    @(negedge iClk);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 0, 0, 1'b0, 4'b0000);
  endtask

  // Streams nPts held-valid points; reports bit count, oSymEnd pulses and last pulse position.
  task automatic runStream(input logic [3:0] r, input int nPts, input bit doFlush,
                           output int bits, output int seCnt, output int sePos);
    int start, ci, cq, budget;
    if (doFlush) step(1'b0, 0, 0, 1'b1, r);
    start = acceptCnt;
    bits = 0; seCnt = 0; sePos = 0;
    ci = int'($urandom_range(0, 255)) - 128;
    cq = int'($urandom_range(0, 255)) - 128;
    budget = nPts * 4 + 8;
    for (int c = 0; c < budget; c++) begin
      step(acceptCnt - start < nPts, ci, cq, 1'b0, r);
      if (obsValid) bits++;
      if (obsSymEnd) begin seCnt++; sePos = bits; end
      if (lastAccept) begin
        ci = int'($urandom_range(0, 255)) - 128;
        cq = int'($urandom_range(0, 255)) - 128;
      end
    end
  endtask

  initial begin
    int bits, seCnt, sePos, ci, cq;
    logic [3:0] codes[8];
    tbl[0]  = '{4'b1101,   32,    0, 1, 4'b0001};
    tbl[1]  = '{4'b1101,  -32,    0, 1, 4'b0000};
    tbl[2]  = '{4'b1101,    0,    0, 1, 4'b0001};
    tbl[3]  = '{4'b1101, -128,    0, 1, 4'b0000};
    tbl[4]  = '{4'b0101,  -32,   32, 2, 4'b0010};
    tbl[5]  = '{4'b0101,   32,  -32, 2, 4'b0001};
    tbl[6]  = '{4'b1001,   96,  -32, 4, 4'b1001};
    tbl[7]  = '{4'b1001,  -64,   63, 4, 4'b1100};
    tbl[8]  = '{4'b1001, -128,   64, 4, 4'b0100};
    tbl[9]  = '{4'b1001,   63,   -1, 4, 4'b1011};
    tbl[10] = '{4'b1111,    5, -100, 1, 4'b0001};
    tbl[11] = '{4'b0000,   -1,    5, 1, 4'b0000};
    tbl[12] = '{4'b1011,  -63,  -65, 4, 4'b0010};
    tbl[13] = '{4'b0111,  127,    0, 2, 4'b0011};
    codes = '{4'b1101, 4'b1111, 4'b0101, 4'b0111, 4'b1001, 4'b1011, 4'b0000, 4'b0110};

    iRst = 1'b1; iRateEN = 1'b0; iRate = 4'b0000; iValid = 1'b0; iI = '0; iQ = '0;
    repeat (2) @(negedge iClk);
    #1;
    check("rst_oValid", oValid, 1'b0);
    check("rst_oReady", oReady, 1'b1);
    check("rst_oData", oData, 1'b0);
    check("rst_oSymEnd", oSymEnd, 1'b0);
    @(negedge iClk);
    iRst = 1'b0;

    // Reset RATE is BPSK: a single bit then idle.
    step(1'b1, -20, 90, 1'b0, 4'b0000);
    step(1'b0, 0, 0, 1'b0, 4'b0000);
    check("rstRate_b0", obsData, 1'b0);
    step(1'b0, 0, 0, 1'b0, 4'b0000);
    check("rstRate_done", obsValid, 1'b0);

    foreach (tbl[t]) begin
      step(1'b0, 0, 0, 1'b1, tbl[t].rate);
      step(1'b1, tbl[t].i, tbl[t].q, 1'b0, 4'b0000);
      for (int k = 0; k < tbl[t].n; k++) begin
        step(1'b0, 0, 0, 1'b0, 4'b0000);
        check($sformatf("tbl%0d_b%0d", t, k), obsData, tbl[t].exp[k]);
      end
      step(1'b0, 0, 0, 1'b0, 4'b0000);
      check($sformatf("tbl%0d_end", t), obsValid, 1'b0);
    end

    // BPSK back-to-back.
    step(1'b0, 0, 0, 1'b1, 4'b1101);
    step(1'b1, 32, 0, 1'b0, 4'b0000);
    step(1'b1, -32, 0, 1'b0, 4'b0000);  check("bpsk_0", obsData, 1'b1);
    step(1'b1, 0, 0, 1'b0, 4'b0000);    check("bpsk_1", obsData, 1'b0);
    step(1'b1, -128, 0, 1'b0, 4'b0000); check("bpsk_2", obsData, 1'b1);
    check("bpsk_rdy", obsReady, 1'b1);
    step(1'b0, 0, 0, 1'b0, 4'b0000);    check("bpsk_3", obsData, 1'b0);
    check("bpsk_v3", obsValid, 1'b1);
    idle(2);

    // QPSK with iValid held: ready only at accept cycles.
    step(1'b0, 0, 0, 1'b1, 4'b0101);
    step(1'b1, -32, 32, 1'b0, 4'b0000); check("qpsk_rdy_t", obsReady, 1'b1);
    step(1'b1, 32, -32, 1'b0, 4'b0000); check("qpsk_rdy_t1", obsReady, 1'b0);
    check("qpsk_b0", obsData, 1'b0);
    step(1'b1, 32, -32, 1'b0, 4'b0000); check("qpsk_rdy_t2", obsReady, 1'b1);
    check("qpsk_b1", obsData, 1'b1);
    step(1'b0, 0, 0, 1'b0, 4'b0000);    check("qpsk_b2", obsData, 1'b1);
    check("qpsk_v2", obsValid, 1'b1);
    step(1'b0, 0, 0, 1'b0, 4'b0000);    check("qpsk_b3", obsData, 1'b0);
    step(1'b0, 0, 0, 1'b0, 4'b0000);    check("qpsk_gap", obsValid, 1'b0);

    // Symbol end at BPSK and 16-QAM, including wrap on the 49th point.
    runStream(4'b1101, 49, 1'b1, bits, seCnt, sePos);
    checkInt("symBpsk_bits", bits, 49);
    checkInt("symBpsk_cnt", seCnt, 1);
    checkInt("symBpsk_pos", sePos, 48);
    runStream(4'b1001, 49, 1'b1, bits, seCnt, sePos);
    checkInt("symQam_bits", bits, 196);
    checkInt("symQam_cnt", seCnt, 1);
    checkInt("symQam_pos", sePos, 192);

    // Flush during the 2nd bit of a 16-QAM point, with scCnt already nonzero.
    runStream(4'b1001, 10, 1'b1, bits, seCnt, sePos);
    step(1'b1, 96, -32, 1'b0, 4'b0000);
    step(1'b0, 0, 0, 1'b0, 4'b0000);    check("flush_b0", obsData, 1'b1);
    step(1'b1, 50, 50, 1'b1, 4'b0101);  check("flush_rdy", obsReady, 1'b0);
    check("flush_b1", obsData, 1'b0);
    step(1'b1, -32, 32, 1'b0, 4'b0000); check("flush_drop", obsValid, 1'b0);
    step(1'b0, 0, 0, 1'b0, 4'b0000);    check("flush_q0", obsData, 1'b0);
    step(1'b0, 0, 0, 1'b0, 4'b0000);    check("flush_q1", obsData, 1'b1);
    step(1'b0, 0, 0, 1'b0, 4'b0000);    check("flush_qend", obsValid, 1'b0);
    runStream(4'b0101, 47, 1'b0, bits, seCnt, sePos);
    checkInt("flush_symCnt", seCnt, 1);
    checkInt("flush_symPos", sePos, 94);

    // Asynchronous reset in the middle of a 16-QAM point.
    runStream(4'b1001, 5, 1'b1, bits, seCnt, sePos);
    step(1'b1, -96, 10, 1'b0, 4'b0000);
    step(1'b0, 0, 0, 1'b0, 4'b0000);
    step(1'b0, 0, 0, 1'b0, 4'b0000);
    check("arst_pre", obsValid, 1'b1);
    #2 iRst = 1'b1;
    #1;
    check("arst_oValid", oValid, 1'b0);
    check("arst_oReady", oReady, 1'b1);
    check("arst_oSymEnd", oSymEnd, 1'b0);
    mq.delete(); pointIdx = 0; mRate = 4'b1101;
    @(negedge iClk);
    iRst = 1'b0;
    runStream(4'b0000, 48, 1'b0, bits, seCnt, sePos);
    checkInt("arst_bits", bits, 48);
    checkInt("arst_symPos", sePos, 48);

    // Randomized traffic against the model.
    ci = 0; cq = 0;
    for (int c = 0; c < 3000; c++) begin
      step($urandom_range(0, 9) < 7, ci, cq, $urandom_range(0, 49) == 0, codes[$urandom_range(0, 7)]);
      if (lastAccept || $urandom_range(0, 3) == 0) begin
        ci = int'($urandom_range(0, 255)) - 128;
        cq = int'($urandom_range(0, 255)) - 128;
      end
    end
    idle(6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/demapper.md
# demapper

Hard-decision constellation demapper for the 802.11a RX chain, directly upstream of `deinterleaver`. It accepts one equalized data-subcarrier point (I/Q) per handshake and slices it to Nbpsc bits using 802.11a Gray mapping. It emits those bits serially, b0 first, one bit per clock on `oData`/`oValid`, which drive the deinterleaver's `iData`/`iEN`. It supports the same RATE codes as the deinterleaver: BPSK, QPSK and 16-QAM.

## Interface
- `W`, 8: signed width of `iI`/`iQ` (two's complement).
- `THR16`, 64: 16-QAM inner/outer decision threshold on |I| and |Q|. Nominal levels are ±THR16/2 and ±3·THR16/2.
- `NSC`, 48: data subcarriers per OFDM symbol.

Ports:
- `iClk`  in  1  clock.
- `iRst`  in  1  reset, asynchronous, active-high.
- `iRateEN`  in  1  load `iRate` into the RATE register; also flushes the block.
- `iRate`  in  4  RATE field (802.11a SIGNAL encoding).
- `iValid`  in  1  input point valid.
- `iI`  in  W  in-phase sample.
- `iQ`  in  W  quadrature sample.
- `oReady`  out  1  block can accept a point this cycle.
- `oData`  out  1  serial output bit.
- `oValid`  out  1  `oData` valid; connects to deinterleaver `iEN`.
- `oSymEnd`  out  1  high together with the last bit of point NSC-1 of an OFDM symbol.

## Operation
- **RATE register.** Reset value 4'b1101 (6 Mb/s). Loaded on `iRateEN`.
- **Nbpsc by RATE.**
  - 1101/1111 → 1 (BPSK).
  - 0101/0111 → 2 (QPSK).
  - 1001/1011 → 4 (16-QAM).
  - Any other code → treated as BPSK.
- **Slicing** (computed combinationally on `iI`/`iQ`; sign test is ≥0 → 1).
  - BPSK: b0 = (I≥0). Q is ignored.
  - QPSK: b0 = (I≥0), b1 = (Q≥0).
  - 16-QAM: b0 = (I≥0), b1 = (|I|<THR16), b2 = (Q≥0), b3 = (|Q|<THR16).
  - |x| is computed in W+1 bits so that −2^(W−1) does not overflow.
  - Values exactly equal to THR16 decide outer (b1/b3 = 0).
- **Shift stage.** A 4-bit shift register plus a bit counter `bitsLeft` (0..4).
  - On accept (`iValid & oReady`): load {b0..b(Nbpsc−1)}, set `bitsLeft` = Nbpsc.
  - Each cycle with `bitsLeft` > 0: present the current bit, shift, decrement.
- **State machine.**
  - IDLE: `bitsLeft` = 0. `oValid` = 0, `oReady` = 1.
  - SHIFT: `bitsLeft` ≥ 1. `oValid` = 1. `oReady` = 1 only when `bitsLeft` = 1.
  - Accepting in the last-bit cycle reloads back-to-back with no bubble.
- **Subcarrier counter** `scCnt` (0..NSC−1).
  - Increments when the last bit of a point is output.
  - Wraps from NSC−1 to 0.
  - `oSymEnd` = `oValid` & (`bitsLeft` = 1) & (`scCnt` = NSC−1).
- **Flush on `iRateEN`.**
  - Clears `bitsLeft`, the shift register and `scCnt`.
  - Drops any point presented in that cycle: `oReady` is forced to 0 while `iRateEN` = 1.
- **Held input.** `iValid` held with `oReady` = 0 holds the point; the upstream block keeps `iI`/`iQ` stable.

## Timing
- **Reset values:** `oData` = 0, `oValid` = 0, `oSymEnd` = 0, `oReady` = 1, RATE = 1101, `scCnt` = 0.
- **Latency:** point accepted at edge t → b0 on `oData` with `oValid` = 1 in cycle t+1 → b(N−1) in cycle t+N.
- **Outputs:**
  - `oData`, `oValid` and `oSymEnd` are register-driven, with no combinational path from `iI`/`iQ`/`iValid`.
  - `oReady` depends only on state and `iRateEN`.
- **Throughput:** with `iValid` held high, output is 100% duty on `oValid` for every rate.
  - BPSK accepts every cycle, QPSK every 2nd, 16-QAM every 4th.
- **Gaps:** if `iValid` is low in an accept cycle, `oValid` falls to 0 after the last bit. The deinterleaver tolerates gaps.
- **Simultaneous events:**
  - `iRateEN` in the same cycle as a last bit: that bit is still output (registered this cycle), but `scCnt` is cleared rather than incremented.
  - `iRst` mid-point: outputs go to reset values immediately (asynchronous) and the partial point is lost.

## Test plan
- **Reset:** assert `iRst` mid-16-QAM point → `oValid` = 0, `oReady` = 1 and `scCnt` = 0 asynchronously; RATE reads 1101 (a BPSK point afterwards outputs 1 bit).
- **BPSK stream** (RATE 1101): points I = +32, −32, 0, −128 on consecutive cycles → `oData` = 1, 0, 1, 0 on cycles t+1..t+4, `oValid` continuously 1, `oReady` never low.
- **QPSK** (RATE 0101): (I,Q) = (−32,+32) then (+32,−32), `iValid` held → `oData` = 0,1,1,0 with no gaps; `oReady` = 1 only at accept cycles t and t+2.
- **16-QAM** (RATE 1001): (I,Q) = (+96,−32) → bits 1,0,0,1. Then (−64,+63) → 0,0,1,1. Boundary case: −128 → b0 = 0, b1 = 0.
- **Symbol end:** 48 BPSK points → `oSymEnd` pulses exactly once, on the 48th bit; `scCnt` wraps and a 49th point gives no pulse. Repeat at 16-QAM → pulse on output bit 192.
- **Flush:** pulse `iRateEN` with `iRate` = 0101 during the 2nd bit of a 16-QAM point → remaining 2 bits suppressed; `oReady` = 0 in that cycle; the next point yields 2 bits; `scCnt` restarts at 0.
